// File: rtl/exp_acc_ctrl.sv
// exp_acc_ctrl: sequencing controller for the exponential-accumulate datapath.
// Optional WAIT-state engine timeout is built only when EXP_ACC_TIMEOUT_EN is defined.
module exp_acc_ctrl #(
  parameter int NSAMP   = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eng_done,
  input  logic             full,
  output logic             ld,
  output logic             sh_en,
  output logic             ld_ui,
  output logic             eng_start,
  output logic             wr_req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] sample_cnt
);
  if (NSAMP < 1 || NSAMP > 2 ** CNT_W || TIMEOUT < 1 || TIMEOUT >= 2 ** TW) begin : g_bad_cfg
    $error("exp_acc_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, ACCEPT, KICK, WAIT, WRITE, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo;

`ifdef EXP_ACC_TIMEOUT_EN
  logic [TW-1:0] tcnt_q;
  logic          err_q;
  assign tmo = state_q == WAIT && !eng_done && tcnt_q == TW'(TIMEOUT - 1);
  // Counter is held at zero outside WAIT, so KICK always starts it fresh.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
      err_q  <= (state_q == IDLE && start) ? 1'b0 : (err_q | tmo);
    end
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (start) begin
        state_d = ACCEPT;
        cnt_d   = '0;
      end
      ACCEPT: if (in_valid) state_d = KICK;
      KICK:   state_d = WAIT;
      WAIT:   state_d = eng_done ? WRITE : tmo ? IDLE : WAIT;
      WRITE:  if (!full) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(NSAMP - 1)) ? FIN : ACCEPT;
      end
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  assign busy       = state_q != IDLE;
  assign in_ready   = state_q == ACCEPT;
  assign ld         = in_ready & in_valid;
  assign sh_en      = ld;
  assign ld_ui      = ld;
  assign eng_start  = state_q == KICK;
  assign wr_req     = state_q == WRITE && !full;
  assign done       = state_q == FIN;
  assign sample_cnt = cnt_q;
endmodule
